// File: rtl/drp_sensor_responder_if.sv
// DRP bus plus external ADC sample-push port of the XADC stand-in.
// slave = the responder, master = the DRP reader / ADC front end.
interface drp_sensor_responder_if;
    logic [6:0]  daddr_in;
    logic        den_in;
    logic        dwe_in;
    logic [15:0] di_in;
    logic [15:0] do_out;
    logic        drdy_out;
    logic        busy_out;
    logic        drp_err_out;
    logic        sample_valid;
    logic [3:0]  sample_chan;
    logic [11:0] sample_data;
    logic        eoc_out;
    logic [4:0]  channel_out;

    modport slave (
        input  daddr_in, den_in, dwe_in, di_in,
        input  sample_valid, sample_chan, sample_data,
        output do_out, drdy_out, busy_out, drp_err_out,
        output eoc_out, channel_out
    );

    modport master (
        output daddr_in, den_in, dwe_in, di_in,
        output sample_valid, sample_chan, sample_data,
        input  do_out, drdy_out, busy_out, drp_err_out,
        input  eoc_out, channel_out
    );
endinterface

// File: rtl/drp_sensor_responder.sv
// XADC-compatible DRP register target fed by an external ADC front end.
// Aux results are stored left-justified; reads complete READ_LATENCY cycles after accept.
module drp_sensor_responder #(
    parameter int unsigned READ_LATENCY = 3,
    parameter logic [15:0] SEQ_MASK_RST = 16'hFFFF
) (
    input  logic                         CLK100MHZ,
    input  logic                         rst_n,
    drp_sensor_responder_if.slave        drp
);
    localparam logic [3:0] LAT = 4'(READ_LATENCY);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  lat_reg;
    logic [6:0]  addr_reg;
    logic        we_reg;
    logic [15:0] di_reg;
    logic [15:0] snap_reg;
    logic [15:0] do_hold_reg;
    logic        err_reg;
    logic [15:0] cfg_reg [3];
    logic [15:0] mask_reg;
    logic [15:0] aux_reg [16];
    logic        eoc_reg;
    logic [4:0]  chan_reg;

    logic        accept;
    logic        done;
    logic [15:0] do_data;
    logic [15:0] rd_data;
    logic [15:0] sample_hit;

    // Register read mux on the live address: the snapshot is taken at the accept edge.
    always_comb begin
        rd_data = 16'h0000;
        if (drp.daddr_in[6:4] == 3'b001) begin
            rd_data = aux_reg[drp.daddr_in[3:0]];
        end else begin
            case (drp.daddr_in)
                7'h40:   rd_data = cfg_reg[0];
                7'h41:   rd_data = cfg_reg[1];
                7'h42:   rd_data = cfg_reg[2];
                7'h48:   rd_data = mask_reg;
                default: rd_data = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (drp.den_in) state_next = WAIT;
            WAIT:    if (lat_reg == LAT) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept  = (state_reg == IDLE) && drp.den_in;
        done    = (state_reg == WAIT) && (lat_reg == LAT);
        do_data = (done && !we_reg) ? snap_reg : do_hold_reg;
    end

    assign drp.drdy_out    = done;
    assign drp.busy_out    = (state_reg == WAIT);
    assign drp.do_out      = do_data;
    assign drp.drp_err_out = err_reg;
    assign drp.eoc_out     = eoc_reg;
    assign drp.channel_out = chan_reg;

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            lat_reg     <= 4'd0;
            addr_reg    <= 7'd0;
            we_reg      <= 1'b0;
            di_reg      <= 16'h0000;
            snap_reg    <= 16'h0000;
            do_hold_reg <= 16'h0000;
            err_reg     <= 1'b0;
            cfg_reg[0]  <= 16'h0000;
            cfg_reg[1]  <= 16'h0000;
            cfg_reg[2]  <= 16'h0000;
            mask_reg    <= SEQ_MASK_RST;
        end else begin
            do_hold_reg <= do_data;
            if (accept) begin
                addr_reg <= drp.daddr_in;
                we_reg   <= drp.dwe_in;
                di_reg   <= drp.di_in;
                snap_reg <= rd_data;
                lat_reg  <= 4'd1;
            end else if (state_reg == WAIT) begin
                lat_reg <= lat_reg + 4'd1;
            end
            if (drp.den_in && state_reg == WAIT) err_reg <= 1'b1;
            // Writes commit at the end of the drdy cycle; writes to aux or unmapped space drop here.
            if (done && we_reg) begin
                case (addr_reg)
                    7'h40:   cfg_reg[0] <= di_reg;
                    7'h41:   cfg_reg[1] <= di_reg;
                    7'h42:   cfg_reg[2] <= di_reg;
                    7'h48:   mask_reg   <= di_reg;
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_hit
            assign sample_hit[gi] = drp.sample_valid && (drp.sample_chan == 4'(gi)) && mask_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) aux_reg[i] <= 16'h0000;
            eoc_reg  <= 1'b0;
            chan_reg <= 5'd0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (sample_hit[i]) aux_reg[i] <= {drp.sample_data, 4'b0000};
            end
            eoc_reg <= |sample_hit;
            if (|sample_hit) chan_reg <= {1'b1, drp.sample_chan};
        end
    end
endmodule
